// File: rtl/l1ca_acq_sequencer.sv
// l1ca_acq_sequencer: walks the PRNs enabled in a mask, runs the coarse then the
// fine search engine on each, thresholds both results and hands every fine hit
// to the tracking side over a valid/ready port.
module l1ca_acq_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter int          DOP_STEP_HZ    = 50,
  parameter int          DOP_BASE_HZ    = -5250
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        sv_mask,
  input  logic [31:0]        coarse_thresh,
  input  logic [31:0]        fine_thresh,
  output logic               coarse_start,
  output logic [4:0]         coarse_sv,
  input  logic               coarse_busy,
  input  logic [31:0]        coarse_acc,
  input  logic [4:0]         coarse_dop_idx,
  input  logic [11:0]        coarse_code_idx,
  output logic               fine_start,
  output logic [4:0]         fine_sv,
  output logic [4:0]         fine_coarse_dop_idx,
  output logic [11:0]        fine_coarse_code_idx,
  input  logic               fine_busy,
  input  logic [31:0]        fine_acc,
  input  logic [13:0]        fine_code_index,
  input  logic [7:0]         fine_dop_index,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [4:0]         res_sv,
  output logic [13:0]        res_code_index,
  output logic signed [15:0] res_dop_hz,
  output logic [31:0]        res_power,
  output logic [5:0]         n_found,
  output logic               timeout_err,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, SCAN, C_START, C_WAIT, F_START, F_WAIT, EMIT, DONE
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, next_state;
  logic [31:0]        mask_q, cthr_q, fthr_q;
  logic [4:0]         sv_idx;
  logic               seen_busy;
  logic [WD_W-1:0]    wd_cnt;
  logic               advance;
  logic               eng_busy, run_end, wd_expired;
  logic signed [15:0] dop_hz_calc;

  // Only one engine is waited on at a time, so one watchdog and one seen_busy serve both.
  assign eng_busy    = (state == C_WAIT) ? coarse_busy : fine_busy;
  assign run_end     = seen_busy & ~eng_busy;
  assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign dop_hz_calc = $signed({8'd0, fine_dop_index}) * 16'(DOP_STEP_HZ) + 16'(DOP_BASE_HZ);

  // The SV under search is presented to both engines straight from the scan index.
  assign coarse_sv = sv_idx;
  assign fine_sv   = sv_idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a finished, failed or abandoned SV funnels into one advance path.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    next_state = state;
    advance    = 1'b0;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN: begin
        if (mask_q[sv_idx])       next_state = C_START;
        else if (sv_idx == 5'd31) next_state = DONE;
      end
      C_START: next_state = C_WAIT;
      C_WAIT: begin
        if (run_end) begin
          if (coarse_acc >= cthr_q) next_state = F_START;
          else                      advance    = 1'b1;
        end else if (wd_expired) begin
          advance = 1'b1;
        end
      end
      F_START: next_state = F_WAIT;
      F_WAIT: begin
        if (run_end) begin
          if (fine_acc >= fthr_q) next_state = EMIT;
          else                    advance    = 1'b1;
        end else if (wd_expired) begin
          advance = 1'b1;
        end
      end
      EMIT:    if (res_ready) advance = 1'b1;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (advance) next_state = (sv_idx == 5'd31) ? DONE : SCAN;
  end

  // Moore outputs decoded from the state, so they drop as soon as reset lands.
  always_comb begin
    coarse_start = (state == C_START);
    fine_start   = (state == F_START);
    res_valid    = (state == EMIT);
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

  // Datapath: scan index, watchdog, latched coarse seed, result and scan status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q               <= '0;
      cthr_q               <= '0;
      fthr_q               <= '0;
      sv_idx               <= '0;
      seen_busy            <= 1'b0;
      wd_cnt               <= '0;
      fine_coarse_dop_idx  <= '0;
      fine_coarse_code_idx <= '0;
      res_sv               <= '0;
      res_code_index       <= '0;
      res_dop_hz           <= '0;
      res_power            <= '0;
      n_found              <= '0;
      timeout_err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask_q      <= sv_mask;
            cthr_q      <= coarse_thresh;
            fthr_q      <= fine_thresh;
            sv_idx      <= '0;
            n_found     <= '0;
            timeout_err <= 1'b0;
          end
        end
        SCAN: begin
          if (!mask_q[sv_idx] && sv_idx != 5'd31) sv_idx <= sv_idx + 5'd1;
        end
        C_START, F_START: begin
          wd_cnt    <= '0;
          seen_busy <= 1'b0;
        end
        C_WAIT, F_WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (eng_busy)               seen_busy   <= 1'b1;
          if (!run_end && wd_expired) timeout_err <= 1'b1;
          if (state == C_WAIT && run_end && coarse_acc >= cthr_q) begin
            fine_coarse_dop_idx  <= coarse_dop_idx;
            fine_coarse_code_idx <= coarse_code_idx;
          end
          if (state == F_WAIT && run_end && fine_acc >= fthr_q) begin
            res_sv         <= sv_idx;
            res_code_index <= fine_code_index;
            res_dop_hz     <= dop_hz_calc;
            res_power      <= fine_acc;
          end
        end
        EMIT: begin
          if (res_ready) n_found <= n_found + 6'd1;
        end
        default: ;
      endcase
      if (advance && sv_idx != 5'd31) sv_idx <= sv_idx + 5'd1;
    end
  end

endmodule

// File: tb/tb_l1ca_acq_sequencer.sv
// tb_l1ca_acq_sequencer: behavioural coarse/fine engines, a randomising result
// consumer and a scoreboard built from the per-PRN engine responses.
module tb_l1ca_acq_sequencer;

  localparam int TMO  = 100;
  localparam int STEP = 50;
  localparam int BASE = -5250;

  logic        clk, rst, start;
  logic [31:0] sv_mask, coarse_thresh, fine_thresh;
  logic        coarse_start, coarse_busy;
  logic [4:0]  coarse_sv, coarse_dop_idx;
  logic [31:0] coarse_acc;
  logic [11:0] coarse_code_idx;
  logic        fine_start, fine_busy;
  logic [4:0]  fine_sv, fine_coarse_dop_idx;
  logic [11:0] fine_coarse_code_idx;
  logic [31:0] fine_acc;
  logic [13:0] fine_code_index;
  logic [7:0]  fine_dop_index;
  logic        res_valid, res_ready;
  logic [4:0]  res_sv;
  logic [13:0] res_code_index;
  logic [15:0] res_dop_hz;
  logic [31:0] res_power;
  logic [5:0]  n_found;
  logic        timeout_err, busy, done;

  l1ca_acq_sequencer #(.TIMEOUT_CYCLES(TMO), .DOP_STEP_HZ(STEP), .DOP_BASE_HZ(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .sv_mask(sv_mask),
    .coarse_thresh(coarse_thresh), .fine_thresh(fine_thresh),
    .coarse_start(coarse_start), .coarse_sv(coarse_sv), .coarse_busy(coarse_busy),
    .coarse_acc(coarse_acc), .coarse_dop_idx(coarse_dop_idx), .coarse_code_idx(coarse_code_idx),
    .fine_start(fine_start), .fine_sv(fine_sv), .fine_coarse_dop_idx(fine_coarse_dop_idx),
    .fine_coarse_code_idx(fine_coarse_code_idx), .fine_busy(fine_busy), .fine_acc(fine_acc),
    .fine_code_index(fine_code_index), .fine_dop_index(fine_dop_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_sv(res_sv),
    .res_code_index(res_code_index), .res_dop_hz(res_dop_hz), .res_power(res_power),
    .n_found(n_found), .timeout_err(timeout_err), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Per-PRN engine responses.
  logic [31:0] c_acc  [32];
  logic [4:0]  c_dop  [32];
  logic [11:0] c_code [32];
  bit          c_hang [32];
  logic [31:0] f_acc  [32];
  logic [13:0] f_code [32];
  logic [7:0]  f_dop  [32];
  int          f_min_dur = 2;

  typedef struct {
    logic [4:0]  sv;
    logic [13:0] code;
    logic [15:0] dop;
    logic [31:0] pwr;
  } res_t;

  res_t exp_res[$];
  int   exp_coarse[$];
  int   exp_fine[$];
  int   exp_hits;
  bit   exp_tmo;
  int   coarse_cnt = 0;
  int   coarse_cyc[$];
  int   start_cyc, done_cyc;
  bit   ready_rand = 1'b1;
  bit   stall_req = 1'b0, stall_done = 1'b0;
  int   stall_left = 0, stall_coarse = 0;
  logic [15:0] last_dop;

  task automatic next_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 32; i++) begin
      c_acc[i] = 0; c_dop[i] = 0; c_code[i] = 0; c_hang[i] = 0;
      f_acc[i] = 0; f_code[i] = 0; f_dop[i] = 0;
    end
  endtask

  // Expected outcome of a scan: visit enabled PRNs in ascending order, apply both thresholds.
  task automatic build(input logic [31:0] mask, input logic [31:0] cthr, input logic [31:0] fthr);
    res_t e;
    exp_res.delete(); exp_coarse.delete(); exp_fine.delete();
    exp_tmo = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        exp_coarse.push_back(i);
        if (c_hang[i]) exp_tmo = 1;
        else if (c_acc[i] >= cthr) begin
          exp_fine.push_back(i);
          if (f_acc[i] >= fthr) begin
            e.sv = 5'(i); e.code = f_code[i];
            e.dop = 16'(BASE + STEP * int'(f_dop[i]));
            e.pwr = f_acc[i];
            exp_res.push_back(e);
          end
        end
      end
    end
    exp_hits = exp_res.size();
  endtask

  task automatic start_scan(input logic [31:0] mask, input logic [31:0] cthr, input logic [31:0] fthr);
    build(mask, cthr, fthr);
    @(negedge clk);
    sv_mask = mask; coarse_thresh = cthr; fine_thresh = fthr; start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    sv_mask = $urandom; coarse_thresh = $urandom; fine_thresh = $urandom;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    done_cyc = cyc;
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_n_found"}, 64'(n_found), 64'(exp_hits));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(exp_tmo));
    check({tag, "_res_left"}, 64'(exp_res.size()), 64'd0);
    check({tag, "_coarse_left"}, 64'(exp_coarse.size()), 64'd0);
    check({tag, "_fine_left"}, 64'(exp_fine.size()), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_after_done"}, 64'({busy, done}), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_starts"}, 64'({coarse_start, fine_start}), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_n_found"}, 64'(n_found), 64'd0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
    check({tag, "_res_fields"}, 64'({res_sv, res_code_index, res_dop_hz}), 64'd0);
    check({tag, "_res_power"}, 64'(res_power), 64'd0);
    check({tag, "_fine_seed"}, 64'({fine_sv, fine_coarse_dop_idx, fine_coarse_code_idx}), 64'd0);
  endtask

  // Coarse engine: optional latency, a busy burst, then results on the busy fall.
  initial begin : coarse_engine
    int s;
    coarse_busy = 0; coarse_acc = 0; coarse_dop_idx = 0; coarse_code_idx = 0;
    forever begin
      @(posedge clk); #1;
      if (coarse_start && !rst) begin
        s = int'(coarse_sv);
        if (!c_hang[s]) begin
          coarse_acc = $urandom;
          next_cyc(int'($urandom_range(0, 3)));
          coarse_busy = 1'b1;
          next_cyc(int'($urandom_range(2, 8)));
          coarse_busy = 1'b0;
          coarse_acc = c_acc[s]; coarse_dop_idx = c_dop[s]; coarse_code_idx = c_code[s];
        end
      end
    end
  end

  // Fine engine.
  initial begin : fine_engine
    int s;
    fine_busy = 0; fine_acc = 0; fine_code_index = 0; fine_dop_index = 0;
    forever begin
      @(posedge clk); #1;
      if (fine_start && !rst) begin
        s = int'(fine_sv);
        fine_acc = $urandom;
        next_cyc(int'($urandom_range(0, 3)));
        fine_busy = 1'b1;
        next_cyc(f_min_dur + int'($urandom_range(0, 6)));
        fine_busy = 1'b0;
        fine_acc = f_acc[s]; fine_code_index = f_code[s]; fine_dop_index = f_dop[s];
      end
    end
  end

  // Engine-start monitors.
  always @(negedge clk) begin
    if (!rst && coarse_start) begin
      coarse_cnt++;
      coarse_cyc.push_back(cyc);
      if (exp_coarse.size() == 0) check("coarse_unexpected", 64'd1, 64'd0);
      else check("coarse_sv", 64'(coarse_sv), 64'(exp_coarse.pop_front()));
    end
    if (!rst && fine_start) begin
      if (exp_fine.size() == 0) check("fine_unexpected", 64'd1, 64'd0);
      else check("fine_sv", 64'(fine_sv), 64'(exp_fine.pop_front()));
      check("fine_seed_dop", 64'(fine_coarse_dop_idx), 64'(c_dop[fine_sv]));
      check("fine_seed_code", 64'(fine_coarse_code_idx), 64'(c_code[fine_sv]));
    end
  end

  // Result consumer with stability checks while stalled.
  logic        prev_valid;
  logic [34:0] prev_id;
  logic [31:0] prev_pwr;
  res_t        acc_e;
  always @(negedge clk) begin
    if (rst) begin
      res_ready  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (res_valid && prev_valid) begin
        check("res_stable_id", 64'({res_sv, res_code_index, res_dop_hz}), 64'(prev_id));
        check("res_stable_pwr", 64'(res_power), 64'(prev_pwr));
      end
      if (res_valid && stall_req) begin
        stall_req = 1'b0; stall_left = 50; stall_coarse = coarse_cnt;
      end
      if (res_valid && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          check("stall_no_scan", 64'(coarse_cnt), 64'(stall_coarse));
          check("stall_busy", 64'(busy), 64'd1);
          stall_done = 1'b1;
        end
      end else begin
        res_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check("res_unexpected", 64'd1, 64'd0);
        else begin
          acc_e = exp_res.pop_front();
          check("res_sv", 64'(res_sv), 64'(acc_e.sv));
          check("res_code_index", 64'(res_code_index), 64'(acc_e.code));
          check("res_dop_hz", 64'(res_dop_hz), 64'(acc_e.dop));
          check("res_power", 64'(res_power), 64'(acc_e.pwr));
        end
        last_dop   = res_dop_hz;
        prev_valid = 1'b0;
      end else begin
        prev_valid = res_valid;
        prev_id    = {res_sv, res_code_index, res_dop_hz};
        prev_pwr   = res_power;
      end
    end
  end

  initial begin : global_limit
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    logic [31:0] cthr, fthr, mask;
    int sel, c0;
    bit got;

    rst = 1'b1; start = 1'b0; sv_mask = 0; coarse_thresh = 0; fine_thresh = 0;
    clear_cfg();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty mask: straight walk of 32 indices.
    clear_cfg();
    c0 = coarse_cnt;
    start_scan(32'h0, 500, 1000);
    wait_done("t1");
    check("t1_latency", 64'(done_cyc - start_cyc), 64'd32);
    check("t1_no_coarse", 64'(coarse_cnt), 64'(c0));

    // Single directed hit on PRN index 4, doppler index 105 -> 0 Hz.
    clear_cfg();
    c_acc[4] = 900; c_dop[4] = 7; c_code[4] = 321;
    f_acc[4] = 2000; f_dop[4] = 105; f_code[4] = 1234;
    ready_rand = 1'b0;
    start_scan(32'h10, 500, 1000);
    wait_done("t2");
    check("t2_dop_zero", 64'(last_dop), 64'd0);

    // Coarse below threshold on both end PRNs.
    clear_cfg();
    c_acc[0] = 100; c_acc[31] = 100;
    start_scan(32'h8000_0001, 500, 1000);
    wait_done("t3");

    // Consumer holds ready low for 50 cycles on the first hit.
    clear_cfg();
    c_acc[1] = 900; f_acc[1] = 2000; f_dop[1] = 0;   f_code[1] = 16383;
    c_acc[5] = 900; f_acc[5] = 1000; f_dop[5] = 210; f_code[5] = 77;
    stall_done = 1'b0; stall_req = 1'b1;
    start_scan(32'h22, 900, 1000);
    wait_done("t4");
    check("t4_stall_seen", 64'(stall_done), 64'd1);
    ready_rand = 1'b1;

    // Coarse engine that never goes busy: watchdog abandons the SV.
    clear_cfg();
    c_hang[3] = 1; c_acc[4] = 900; f_acc[4] = 5;
    coarse_cyc.delete();
    start_scan(32'h18, 500, 1000);
    wait_done("t5");
    check("t5_two_coarse", 64'(coarse_cyc.size()), 64'd2);
    if (coarse_cyc.size() == 2)
      check("t5_gap", 64'(coarse_cyc[1] - coarse_cyc[0]), 64'(TMO + 2));

    // Randomised scans against the scoreboard, with threshold-equality cases.
    for (int it = 0; it < 6; it++) begin
      cthr = $urandom_range(1, 1000);
      fthr = $urandom_range(1, 3000);
      mask = (it == 0) ? 32'hFFFF_FFFF : $urandom;
      for (int i = 0; i < 32; i++) begin
        c_hang[i] = ($urandom_range(0, 9) == 0);
        sel = int'($urandom_range(0, 3));
        c_acc[i] = (sel == 0) ? cthr - 1 : (sel == 1) ? cthr : 32'($urandom_range(0, 2000));
        sel = int'($urandom_range(0, 3));
        f_acc[i] = (sel == 0) ? fthr - 1 : (sel == 1) ? fthr : 32'($urandom_range(0, 6000));
        c_dop[i]  = 5'($urandom_range(0, 20));
        c_code[i] = 12'($urandom);
        f_dop[i]  = 8'($urandom_range(0, 210));
        f_code[i] = 14'($urandom);
      end
      start_scan(mask, cthr, fthr);
      if (it == 1) begin
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_done($sformatf("rand%0d", it));
    end

    // Reset while the fine engine runs, then a fresh scan from PRN index 0.
    clear_cfg();
    c_acc[2] = 900; c_dop[2] = 9; c_code[2] = 555; f_acc[2] = 2000; f_dop[2] = 3;
    f_min_dur = 40;
    start_scan(32'h4, 500, 1000);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (fine_start) got = 1'b1;
    end
    check("t6_fine_started", 64'(got), 64'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6_rst");
    exp_res.delete(); exp_coarse.delete(); exp_fine.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    f_min_dur = 2;
    c_acc[0] = 900; f_acc[0] = 1500; f_dop[0] = 200; f_code[0] = 42;
    start_scan(32'h5, 500, 1000);
    wait_done("t6_rescan");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
